// File: rtl/tree_space_manager.sv
// Free-list allocator for BST node slots: a LIFO of node indices, rebuilt after reset
// and whenever the root is freed. Pure bookkeeping, never touches RAM.
module tree_space_manager #(
    parameter int unsigned RAM_DATA_WIDTH = 32,
    parameter int unsigned RAM_ADDR_WIDTH = 16,
    parameter int unsigned RAM_STRB_WIDTH = RAM_DATA_WIDTH / 8,
    parameter int unsigned NB_NODES       = 64,
    parameter int unsigned CNT_W          = $clog2(NB_NODES + 1)
) (
    input  logic                      aclk,
    input  logic                      areset,
    output logic                      tree_ready,
    input  logic                      tree_mgt_req_valid,
    output logic                      tree_mgt_req_ready,
    output logic [RAM_ADDR_WIDTH-1:0] tree_mgt_req_addr,
    input  logic                      tree_mgt_free_valid,
    output logic                      tree_mgt_free_ready,
    input  logic [RAM_ADDR_WIDTH-1:0] tree_mgt_free_addr,
    input  logic                      tree_mgt_free_is_root,
    output logic [CNT_W-1:0]          free_count,
    output logic [2:0]                err_status
);

    localparam int unsigned ADDR_LSB = $clog2(RAM_STRB_WIDTH);
    localparam int unsigned IDX_W    = $clog2(NB_NODES);
    localparam int unsigned FIDX_W   = RAM_ADDR_WIDTH - ADDR_LSB;
    localparam logic [RAM_ADDR_WIDTH-1:0] LSB_MASK = RAM_ADDR_WIDTH'((1 << ADDR_LSB) - 1);

    typedef enum logic {StInit, StRun} state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_stack [NB_NODES];
    logic [CNT_W-1:0]   r_sp, w_sp_nxt;
    logic [IDX_W-1:0]   r_init_idx, w_init_idx_nxt;
    logic [2:0]         r_err, w_err_nxt;

    logic               w_wr_en;
    logic [IDX_W-1:0]   w_wr_ptr, w_wr_data;
    logic [FIDX_W-1:0]  w_free_idx_full;
    logic [IDX_W-1:0]   w_free_idx, w_top;
    logic               w_run, w_pop, w_free_hs, w_mis, w_oor, w_full_err, w_legal;

    assign w_run           = (r_state == StRun);
    assign w_top           = IDX_W'(r_sp - 1'b1);
    assign w_free_idx_full = tree_mgt_free_addr[RAM_ADDR_WIDTH-1:ADDR_LSB];
    assign w_free_idx      = IDX_W'(w_free_idx_full);
    assign w_pop           = w_run && tree_mgt_req_valid && (r_sp != '0);
    assign w_free_hs       = w_run && tree_mgt_free_valid;
    assign w_mis           = (tree_mgt_free_addr & LSB_MASK) != '0;
    assign w_oor           = 32'(w_free_idx_full) >= NB_NODES;
    // A full stack can still take a free if the same cycle pops a slot.
    assign w_full_err      = (r_sp == CNT_W'(NB_NODES)) && !w_pop;
    assign w_legal         = w_free_hs && !w_mis && !w_oor && !w_full_err;

    always_comb begin
        w_state_nxt    = r_state;
        w_sp_nxt       = r_sp;
        w_init_idx_nxt = r_init_idx;
        w_err_nxt      = r_err;
        w_wr_en        = 1'b0;
        w_wr_ptr       = r_init_idx;
        w_wr_data      = IDX_W'(NB_NODES - 1) - r_init_idx;
        unique case (r_state)
            StInit: begin
                w_wr_en        = 1'b1;
                w_init_idx_nxt = r_init_idx + 1'b1;
                if (r_init_idx == IDX_W'(NB_NODES - 1)) begin
                    w_sp_nxt       = CNT_W'(NB_NODES);
                    w_init_idx_nxt = '0;
                    w_state_nxt    = StRun;
                end
            end
            StRun: begin
                if (w_free_hs) begin
                    if (w_mis)           w_err_nxt[1] = 1'b1;
                    else if (w_oor)      w_err_nxt[0] = 1'b1;
                    else if (w_full_err) w_err_nxt[2] = 1'b1;
                end
                if (w_legal && w_pop) begin
                    w_wr_en   = 1'b1;
                    w_wr_ptr  = w_top;
                    w_wr_data = w_free_idx;
                end else if (w_legal) begin
                    w_wr_en   = 1'b1;
                    w_wr_ptr  = IDX_W'(r_sp);
                    w_wr_data = w_free_idx;
                    w_sp_nxt  = r_sp + 1'b1;
                end else if (w_pop) begin
                    w_sp_nxt  = r_sp - 1'b1;
                end
                if (w_free_hs && tree_mgt_free_is_root) begin
                    w_state_nxt    = StInit;
                    w_sp_nxt       = '0;
                    w_init_idx_nxt = '0;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state    <= StInit;
            r_sp       <= '0;
            r_init_idx <= '0;
            r_err      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sp       <= w_sp_nxt;
            r_init_idx <= w_init_idx_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Slot storage needs no reset: it is only read while sp != 0, i.e. after INIT.
    always_ff @(posedge aclk) begin
        if (w_wr_en) r_stack[w_wr_ptr] <= w_wr_data;
    end

    assign tree_ready          = w_run;
    assign tree_mgt_req_ready  = w_run && (r_sp != '0);
    assign tree_mgt_free_ready = w_run;
    assign tree_mgt_req_addr   = (r_sp != '0) ?
                                 (RAM_ADDR_WIDTH'(r_stack[w_top]) << ADDR_LSB) : '0;
    assign free_count          = r_sp;
    assign err_status          = r_err;

endmodule

// File: tb/tb_tree_space_manager.sv
// Scoreboard bench for tree_space_manager with 8 slots of 32-bit nodes (4-byte stride).
module tb_tree_space_manager;
    localparam int NB = 8;
    localparam int AW = 16;
    localparam int CW = 4;

    logic          aclk = 1'b0;
    logic          areset;
    logic          tree_ready;
    logic          req_valid, req_ready;
    logic [AW-1:0] req_addr;
    logic          free_valid, free_ready, free_is_root;
    logic [AW-1:0] free_addr;
    logic [CW-1:0] free_count;
    logic [2:0]    err_status;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [AW-1:0] exp_q[$];
    int            mstk[$];
    logic [2:0]    m_err;

    tree_space_manager #(
        .RAM_DATA_WIDTH(32),
        .RAM_ADDR_WIDTH(AW),
        .NB_NODES      (NB)
    ) dut (
        .aclk                 (aclk),
        .areset               (areset),
        .tree_ready           (tree_ready),
        .tree_mgt_req_valid   (req_valid),
        .tree_mgt_req_ready   (req_ready),
        .tree_mgt_req_addr    (req_addr),
        .tree_mgt_free_valid  (free_valid),
        .tree_mgt_free_ready  (free_ready),
        .tree_mgt_free_addr   (free_addr),
        .tree_mgt_free_is_root(free_is_root),
        .free_count           (free_count),
        .err_status           (err_status)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pop handshakes resolve at the next rising edge; compare mid-cycle.
    always @(negedge aclk) begin
        if (req_valid && req_ready) begin
            check_eq("sb_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check_eq("pop_addr", req_addr, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_reset_vals();
        check_eq("rst_tree_ready", tree_ready, 0);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_free_ready", free_ready, 0);
        check_eq("rst_req_addr", req_addr, 0);
        check_eq("rst_free_count", free_count, 0);
        check_eq("rst_err", err_status, 0);
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (!tree_ready && n < 40) begin
            tick();
            n++;
        end
        check_eq(tag, n, NB);
        mstk.delete();
        for (int k = NB - 1; k >= 0; k--) mstk.push_back(k);
    endtask

    task automatic do_cycle(input bit pop, input bit fr, input logic [AW-1:0] addr, input bit root);
        bit full;
        req_valid    = pop;
        free_valid   = fr;
        free_addr    = addr;
        free_is_root = root;
        full = !pop && (mstk.size() == NB);
        if (pop) begin
            exp_q.push_back(AW'(mstk[$] << 2));
            void'(mstk.pop_back());
        end
        if (fr) begin
            if (addr[1:0] != 2'b00)      m_err[1] = 1'b1;
            else if ((addr >> 2) >= NB)  m_err[0] = 1'b1;
            else if (full)               m_err[2] = 1'b1;
            else                         mstk.push_back(int'(addr >> 2));
            if (root) mstk.delete();
        end
        tick();
        req_valid    = 1'b0;
        free_valid   = 1'b0;
        free_is_root = 1'b0;
        free_addr    = '0;
        if (fr && root) check_eq("root_ready_drop", tree_ready, 0);
        else            check_eq("free_count", free_count, mstk.size());
        check_eq("err_status", err_status, m_err);
    endtask

    initial begin
        areset = 1'b1;
        req_valid = 1'b0;
        free_valid = 1'b0;
        free_is_root = 1'b0;
        free_addr = '0;
        m_err = '0;
        repeat (2) tick();
        check_reset_vals();
        areset = 1'b0;
        wait_init("init_len");
        check_eq("init_count", free_count, 8);
        check_eq("init_addr", req_addr, 0);
        check_eq("init_req_ready", req_ready, 1);
        check_eq("init_free_ready", free_ready, 1);

        for (int k = 0; k < NB; k++) begin
            check_eq("pop_seq", req_addr, k * 4);
            do_cycle(1, 0, '0, 0);
        end
        check_eq("empty_req_ready", req_ready, 0);
        check_eq("empty_count", free_count, 0);
        req_valid = 1'b1;
        repeat (3) tick();
        check_eq("stall_req_ready", req_ready, 0);
        check_eq("stall_count", free_count, 0);
        req_valid = 1'b0;

        do_cycle(0, 1, 16'h0000, 1);
        wait_init("reinit_len");
        repeat (3) do_cycle(1, 0, '0, 0);
        check_eq("alloc3_count", free_count, 5);
        do_cycle(0, 1, 16'h0004, 0);
        check_eq("free4_count", free_count, 6);
        check_eq("free4_top", req_addr, 16'h0004);
        do_cycle(1, 0, '0, 0);
        check_eq("repop_count", free_count, 5);

        check_eq("swap_top", req_addr, 16'h000C);
        do_cycle(1, 1, 16'h0004, 0);
        check_eq("swap_count", free_count, 5);
        check_eq("swap_next", req_addr, 16'h0004);

        do_cycle(0, 1, 16'h0000, 1);
        wait_init("reinit2_len");
        do_cycle(0, 1, 16'h0010, 0);
        check_eq("err_full", err_status, 3'b100);
        check_eq("full_count", free_count, 8);
        do_cycle(0, 1, 16'h0006, 0);
        check_eq("err_mis", err_status, 3'b110);
        do_cycle(0, 1, 16'h0040, 0);
        check_eq("err_oor", err_status, 3'b111);

        repeat (2) do_cycle(1, 0, '0, 0);
        do_cycle(0, 1, 16'h0000, 1);
        wait_init("root_init_len");
        check_eq("root_count", free_count, 8);
        check_eq("root_addr", req_addr, 0);
        check_eq("root_err_kept", err_status, 3'b111);

        do_cycle(1, 1, 16'h0000, 1);
        repeat (2) tick();
        areset = 1'b1;
        #1;
        check_reset_vals();
        m_err = '0;
        tick();
        areset = 1'b0;
        wait_init("rst_init_len");
        check_eq("rst_final_count", free_count, 8);
        check_eq("rst_final_addr", req_addr, 0);
        check_eq("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
